tx_clock_bank: RTL and testbench
================================

TX_CLOCK_BANK -- requirements
Module: tx_clock_bank

Interface
REQ-001 Parameter: N_CH, default 2, number of independent TX clock channels (1..16).
REQ-002 Parameter: PERIOD_WIDTH, default 16, width of each channel period in TIME_FORMAT LSBs.
REQ-003 Parameter: JITTER_WIDTH, default 8, width of the signed per-edge jitter term (2..PERIOD_WIDTH-1).
REQ-004 Parameter: LFSR_INIT, default 2, base LFSR seed; channel i seeds with LFSR_INIT+i (a nonzero value required).
REQ-005 Port: clk  in  1  emulator clock; the single clock of the block.
REQ-006 Port: rst  in  1  reset; asynchronous, active-high.
REQ-007 Port: time_next  in  TIME_FORMAT  emulated time of the current emulation step.
REQ-008 Port: period  in  N_CH*PERIOD_WIDTH  channel i nominal period in slice [i*PERIOD_WIDTH +: PERIOD_WIDTH], unsigned.
REQ-009 Port: en  in  N_CH  per-channel enable.
REQ-010 Port: jitter_en  in  1  global jitter enable.
REQ-011 Port: time_clock  out  N_CH x TIME_FORMAT  next scheduled edge time per channel.
REQ-012 Port: time_eq  out  N_CH  channel edge coincides with time_next this cycle.
REQ-013 Port: cke_out  out  N_CH  one-cycle clock-enable pulse, registered copy of time_eq.
REQ-014 Port: time_min  out  TIME_FORMAT  earliest time_clock over enabled channels; TIME_MAX if none enabled.

Function
REQ-015 Channel state: en_q (registered en), time_clock, 16-bit LFSR.
REQ-016 time_eq[i] SHALL be combinational: en_q[i] AND (time_next == time_clock[i]).
REQ-017 Enable rising edge (en[i]=1, en_q[i]=0): time_clock[i] <= time_next + period_i next cycle; LFSR unchanged; no time_eq that cycle.
REQ-018 Enable falling edge: time_clock[i] <= TIME_MAX next cycle; pending edge discarded; LFSR held.
REQ-019 When time_eq[i]=1: time_clock[i] <= time_clock[i] + step_i; LFSR[i] advances one step.
REQ-020 step_i = period_i + jit_i, with jit_i = sign-extended low JITTER_WIDTH LFSR bits when jitter_en=1, else 0; step computed at PERIOD_WIDTH+1 bits signed.
REQ-021 If step_i < 1, step_i SHALL saturate to 1 (edge never scheduled at or before current time).
REQ-022 LFSR: Fibonacci, taps 16,14,13,11, shift toward MSB; holds when jitter_en=0 or time_eq[i]=0.
REQ-023 Otherwise time_clock[i] holds; period changes take effect at the next scheduled step only.
REQ-024 Time addition wraps modulo 2^TIME_WIDTH; no overflow flag.
REQ-025 cke_out[i] SHALL equal time_eq[i] delayed exactly one clk cycle.
REQ-026 time_min combinational min over channels with en_q=1; ties irrelevant (value only).
REQ-027 Simultaneous time_eq on several channels: each channel updates independently in the same cycle.
REQ-028 en deassert in same cycle as time_eq: disable wins; cke_out still pulses next cycle.

Reset
REQ-029 While rst=1: en_q=0, time_clock[i]=TIME_MAX, LFSR[i]=LFSR_INIT+i, cke_out=0, hence time_eq=0 and time_min=TIME_MAX.
REQ-030 Reset asserted mid-operation SHALL clear all state immediately, independent of clk; first post-reset schedule requires an en rising edge.

Structure
REQ-031 TIME_FORMAT, TIME_WIDTH, TIME_MAX (all ones) and TX_BANK_LFSR_WIDTH=16 SHALL live in time_package.
REQ-032 One sub-module tx_clock_channel (one channel: en edge detect, scheduler, LFSR, saturation), generated N_CH times; min tree in top.

Verification
REQ-033 Reset, N_CH=2, en=00 -> time_clock both TIME_MAX, time_min=TIME_MAX, cke_out=00.
REQ-034 jitter_en=0, period0=100, en0 rise at time_next=0 -> time_clock0=100; time_next=100 -> time_eq0=1, next cycle cke_out0=1, time_clock0=200.
REQ-035 jitter_en=1, JITTER_WIDTH=8, period0=100, seed 2 -> step sequence matches reference LFSR model, all steps in [-28..227] clamped ≥1, for 1000 edges.
REQ-036 period0=3, JITTER_WIDTH=8, forced jit=-100 -> step saturates to 1.
REQ-037 Two channels periods 100 and 50, both enabled at 0 -> time_min tracks 50,100,100(tie),150,...; coincident edge at 100 raises both time_eq.
REQ-038 rst asserted between edges with en held 1 -> all outputs reset asynchronously; no edges until en toggles 0→1.

Source files
------------

// File: rtl/time_package.sv
// Shared time base definitions and the LFSR helper used by the TX clock bank.
package time_package;

   localparam int TIME_WIDTH         = 32;
   localparam int TX_BANK_LFSR_WIDTH = 16;

   typedef logic [TIME_WIDTH-1:0] TIME_FORMAT;

   localparam TIME_FORMAT TIME_MAX = {TIME_WIDTH{1'b1}};

   // Fibonacci LFSR step: taps 16,14,13,11, shifting toward the MSB.
   function automatic logic [TX_BANK_LFSR_WIDTH-1:0] lfsr_next(
      input logic [TX_BANK_LFSR_WIDTH-1:0] s
   );
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/tx_clock_bank_if.sv
// Emulation-step bus of the TX clock bank: time/period/enable in, schedule out.
interface tx_clock_bank_if #(
   parameter int N_CH         = 2,
   parameter int PERIOD_WIDTH = 16
);
   import time_package::*;

   TIME_FORMAT                     time_next;
   logic [N_CH*PERIOD_WIDTH-1:0]   period;
   logic [N_CH-1:0]                en;
   logic                           jitter_en;
   TIME_FORMAT [N_CH-1:0]          time_clock;
   logic [N_CH-1:0]                time_eq;
   logic [N_CH-1:0]                cke_out;
   TIME_FORMAT                     time_min;

   modport master (
      output time_next, period, en, jitter_en,
      input  time_clock, time_eq, cke_out, time_min
   );

   modport slave (
      input  time_next, period, en, jitter_en,
      output time_clock, time_eq, cke_out, time_min
   );
endinterface

// File: rtl/tx_clock_channel.sv
// One TX clock channel: enable edge detect, edge scheduler, jitter LFSR, step saturation.
module tx_clock_channel
   import time_package::*;
#(
   parameter int                            PERIOD_WIDTH = 16,
   parameter int                            JITTER_WIDTH = 8,
   parameter logic [TX_BANK_LFSR_WIDTH-1:0] LFSR_SEED    = 16'd2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  TIME_FORMAT              time_next,
   input  logic [PERIOD_WIDTH-1:0] period,
   input  logic                    en,
   input  logic                    jitter_en,
   output TIME_FORMAT              time_clock,
   output logic                    time_eq,
   output logic                    cke_out,
   output logic                    active
);

   // One guard bit above the signed period+1 width so a near-maximum period
   // plus positive jitter cannot wrap into the negative range.
   localparam int SW = PERIOD_WIDTH + 2;

   logic                          en_q_r;
   logic                          armed_r;
   TIME_FORMAT                    time_clock_r;
   logic [TX_BANK_LFSR_WIDTH-1:0] lfsr_r;
   logic                          cke_r;

   logic                          eq_s;
   logic                          rise_s;
   logic                          fall_s;
   logic signed [SW-1:0]          jit_s;
   logic signed [SW-1:0]          step_raw_s;
   logic [SW-1:0]                 step_s;
   logic                          en_q_nxt_s;
   logic                          armed_nxt_s;
   TIME_FORMAT                    time_clock_nxt_s;
   logic [TX_BANK_LFSR_WIDTH-1:0] lfsr_nxt_s;

   // Edge detection, jittered step with saturation, and next-state selection.
   always_comb begin
      eq_s   = en_q_r & (time_next == time_clock_r);
      // armed_r blocks an enable held high through reset from counting as a rising edge.
      rise_s = en & ~en_q_r & armed_r;
      fall_s = ~en & en_q_r;

      if (jitter_en) begin
         jit_s = {{(SW-JITTER_WIDTH){lfsr_r[JITTER_WIDTH-1]}}, lfsr_r[JITTER_WIDTH-1:0]};
      end else begin
         jit_s = {SW{1'b0}};
      end
      step_raw_s = $signed({2'b00, period}) + jit_s;
      // Never schedule at or before the current edge: clamp to one LSB.
      if (step_raw_s[SW-1] || (step_raw_s == {SW{1'b0}})) begin
         step_s = {{(SW-1){1'b0}}, 1'b1};
      end else begin
         step_s = $unsigned(step_raw_s);
      end

      en_q_nxt_s       = en & (en_q_r | armed_r);
      armed_nxt_s      = armed_r | ~en;
      time_clock_nxt_s = time_clock_r;
      lfsr_nxt_s       = lfsr_r;
      if (rise_s) begin
         time_clock_nxt_s = time_next + TIME_FORMAT'(period);
      end else if (fall_s) begin
         time_clock_nxt_s = TIME_MAX;
      end else if (eq_s) begin
         time_clock_nxt_s = time_clock_r + TIME_FORMAT'(step_s);
         if (jitter_en) begin
            lfsr_nxt_s = lfsr_next(lfsr_r);
         end else begin
            lfsr_nxt_s = lfsr_r;
         end
      end else begin
         time_clock_nxt_s = time_clock_r;
      end
   end

   // Channel state registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q_r       <= 1'b0;
         armed_r      <= 1'b0;
         time_clock_r <= TIME_MAX;
         lfsr_r       <= LFSR_SEED;
         cke_r        <= 1'b0;
      end else begin
         en_q_r       <= en_q_nxt_s;
         armed_r      <= armed_nxt_s;
         time_clock_r <= time_clock_nxt_s;
         lfsr_r       <= lfsr_nxt_s;
         cke_r        <= eq_s;
      end
   end

   assign time_clock = time_clock_r;
   assign time_eq    = eq_s;
   assign cke_out    = cke_r;
   assign active     = en_q_r;

endmodule

// File: rtl/tx_clock_bank.sv
// Bank of N_CH independent TX clock channels plus earliest-edge reduction.
module tx_clock_bank
   import time_package::*;
#(
   parameter int N_CH         = 2,
   parameter int PERIOD_WIDTH = 16,
   parameter int JITTER_WIDTH = 8,
   parameter int LFSR_INIT    = 2
) (
   input  logic            clk,
   input  logic            rst,
   tx_clock_bank_if.slave  bus
);

   TIME_FORMAT [N_CH-1:0] time_clock_s;
   logic [N_CH-1:0]       time_eq_s;
   logic [N_CH-1:0]       cke_s;
   logic [N_CH-1:0]       active_s;
   TIME_FORMAT            time_min_s;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      tx_clock_channel #(
         .PERIOD_WIDTH (PERIOD_WIDTH),
         .JITTER_WIDTH (JITTER_WIDTH),
         .LFSR_SEED    (TX_BANK_LFSR_WIDTH'(LFSR_INIT + g))
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .time_next  (bus.time_next),
         .period     (bus.period[g*PERIOD_WIDTH +: PERIOD_WIDTH]),
         .en         (bus.en[g]),
         .jitter_en  (bus.jitter_en),
         .time_clock (time_clock_s[g]),
         .time_eq    (time_eq_s[g]),
         .cke_out    (cke_s[g]),
         .active     (active_s[g])
      );
   end

   // Earliest scheduled edge over enabled channels; TIME_MAX when none is enabled.
   always_comb begin
      time_min_s = TIME_MAX;
      for (int i = 0; i < N_CH; i++) begin
         if (active_s[i] && (time_clock_s[i] < time_min_s)) begin
            time_min_s = time_clock_s[i];
         end else begin
            time_min_s = time_min_s;
         end
      end
   end

   assign bus.time_clock = time_clock_s;
   assign bus.time_eq    = time_eq_s;
   assign bus.cke_out    = cke_s;
   assign bus.time_min   = time_min_s;

endmodule

// File: tb/tb_tx_clock_bank.sv
// Self-checking bench for tx_clock_bank: directed table, async reset, random jitter run.
module tb_tx_clock_bank;
   import time_package::*;

   localparam logic [31:0] M = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tx_clock_bank_if #(.N_CH(2), .PERIOD_WIDTH(16)) bus_a ();
   tx_clock_bank_if #(.N_CH(1), .PERIOD_WIDTH(16)) bus_b ();

   tx_clock_bank #(.N_CH(2), .PERIOD_WIDTH(16), .JITTER_WIDTH(8), .LFSR_INIT(2))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   // Seed 0x9C makes the first jitter term -100.
   tx_clock_bank #(.N_CH(1), .PERIOD_WIDTH(16), .JITTER_WIDTH(8), .LFSR_INIT(156))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   typedef struct {
      logic [1:0]  en;
      logic [31:0] tn;
      logic [31:0] tc0;
      logic [31:0] tc1;
      logic [1:0]  eq;
      logic [1:0]  cke;
      logic [31:0] mn;
   } vec_t;

   vec_t vecs [15];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: one entry per channel of dut_a.
   int          m_act [2];
   int          m_arm [2];
   int          m_cke [2];
   int          m_lfsr[2];
   logic [31:0] m_tc  [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive_a(input logic [1:0] en, input logic [31:0] tn);
      @(negedge clk);
      bus_a.en        = en;
      bus_a.time_next = tn;
      #1;
   endtask

   task automatic check_a(input string tag, input logic [31:0] tc0, input logic [31:0] tc1,
                          input logic [1:0] eq, input logic [1:0] cke, input logic [31:0] mn);
      chk({tag, "_tc0"}, bus_a.time_clock[0], tc0);
      chk({tag, "_tc1"}, bus_a.time_clock[1], tc1);
      chk({tag, "_eq"},  {30'd0, bus_a.time_eq}, {30'd0, eq});
      chk({tag, "_cke"}, {30'd0, bus_a.cke_out}, {30'd0, cke});
      chk({tag, "_min"}, bus_a.time_min, mn);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 0; m_arm[i] = 0; m_cke[i] = 0; m_tc[i] = M; m_lfsr[i] = 2 + i;
      end
   endtask

   function automatic logic [31:0] model_min();
      logic [31:0] mn = M;
      for (int i = 0; i < 2; i++) if (m_act[i] != 0 && m_tc[i] < mn) mn = m_tc[i];
      return mn;
   endfunction

   function automatic int model_eq(input int i, input logic [31:0] tn);
      return (m_act[i] != 0 && tn == m_tc[i]) ? 1 : 0;
   endfunction

   // Advance the model across one clock edge, following the channel rules directly.
   task automatic model_update(input logic [1:0] en, input logic [31:0] tn,
                               input int p0, input int p1, input logic jen);
      int eq, p, low, jit, step, fb;
      for (int i = 0; i < 2; i++) begin
         eq = model_eq(i, tn);
         p  = (i == 0) ? p0 : p1;
         if (en[i] && m_act[i] == 0 && m_arm[i] != 0) begin
            m_tc[i] = tn + 32'(p); m_act[i] = 1;
         end else if (!en[i] && m_act[i] != 0) begin
            m_tc[i] = M; m_act[i] = 0;
         end else if (eq != 0) begin
            low  = m_lfsr[i] % 256;
            jit  = jen ? ((low >= 128) ? low - 256 : low) : 0;
            step = p + jit;
            if (step < 1) step = 1;
            m_tc[i] = m_tc[i] + 32'(step);
            if (jen) begin
               fb = ((m_lfsr[i] >> 15) ^ (m_lfsr[i] >> 13) ^ (m_lfsr[i] >> 12) ^ (m_lfsr[i] >> 10)) & 1;
               m_lfsr[i] = ((m_lfsr[i] * 2) % 65536) + fb;
            end
         end
         m_cke[i] = eq;
         if (!en[i]) m_arm[i] = 1;
      end
   endtask

   initial begin
      logic [1:0]  en_r;
      logic [31:0] tn, cur, mn, prev_tc0, delta;
      int          p1, edges0, have_prev, cyc;

      bus_a.en = 2'b00; bus_a.time_next = 32'd0; bus_a.jitter_en = 1'b0;
      bus_a.period = {16'd50, 16'd100};
      bus_b.en = 1'b0;  bus_b.time_next = 32'd0; bus_b.jitter_en = 1'b1;
      bus_b.period = 16'd3;

      // Reset state while rst is held.
      repeat (2) @(posedge clk);
      #1;
      check_a("reset", M, M, 2'b00, 2'b00, M);
      @(negedge clk);
      rst = 1'b0;

      // Directed table: periods 100 / 50, jitter off.
      vecs[0]  = '{2'b00, 32'd0,          M,       M,       2'b00, 2'b00, M};
      vecs[1]  = '{2'b11, 32'd0,          M,       M,       2'b00, 2'b00, M};
      vecs[2]  = '{2'b11, 32'd10,         32'd100, 32'd50,  2'b00, 2'b00, 32'd50};
      vecs[3]  = '{2'b11, 32'd50,         32'd100, 32'd50,  2'b10, 2'b00, 32'd50};
      vecs[4]  = '{2'b11, 32'd60,         32'd100, 32'd100, 2'b00, 2'b10, 32'd100};
      vecs[5]  = '{2'b11, 32'd100,        32'd100, 32'd100, 2'b11, 2'b00, 32'd100};
      vecs[6]  = '{2'b11, 32'd120,        32'd200, 32'd150, 2'b00, 2'b11, 32'd150};
      vecs[7]  = '{2'b11, 32'd150,        32'd200, 32'd150, 2'b10, 2'b00, 32'd150};
      vecs[8]  = '{2'b01, 32'd150,        32'd200, 32'd200, 2'b00, 2'b10, 32'd200};
      vecs[9]  = '{2'b01, 32'd160,        32'd200, M,       2'b00, 2'b00, 32'd200};
      vecs[10] = '{2'b00, 32'd200,        32'd200, M,       2'b01, 2'b00, 32'd200};
      vecs[11] = '{2'b00, 32'd210,        M,       M,       2'b00, 2'b01, M};
      vecs[12] = '{2'b01, 32'hFFFF_FFEC,  M,       M,       2'b00, 2'b00, M};
      vecs[13] = '{2'b01, 32'd80,         32'd80,  M,       2'b01, 2'b00, 32'd80};
      vecs[14] = '{2'b01, 32'd0,          32'd180, M,       2'b00, 2'b01, 32'd180};
      for (int v = 0; v < 15; v++) begin
         drive_a(vecs[v].en, vecs[v].tn);
         check_a($sformatf("vec%0d", v), vecs[v].tc0, vecs[v].tc1, vecs[v].eq, vecs[v].cke, vecs[v].mn);
      end

      // Asynchronous reset between edges with enables held high.
      drive_a(2'b00, 32'd300);
      drive_a(2'b11, 32'd400);
      drive_a(2'b11, 32'd450);
      check_a("pre_rst", 32'd500, 32'd450, 2'b10, 2'b00, 32'd450);
      #2 rst = 1'b1;
      #1;
      check_a("async_rst", M, M, 2'b00, 2'b00, M);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive_a(2'b11, 32'd500 + 32'(k * 50));
         check_a($sformatf("post_rst%0d", k), M, M, 2'b00, 2'b00, M);
      end
      drive_a(2'b00, 32'd600);
      drive_a(2'b11, 32'd1000);
      drive_a(2'b11, 32'd1010);
      check_a("re_enable", 32'd1100, 32'd1050, 2'b00, 2'b00, 32'd1050);

      // Random run: channel 0 jittered at period 100, channel 1 random period/enable.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      bus_a.jitter_en = 1'b1;
      p1 = 50; en_r = 2'b00; cur = 32'd0; edges0 = 0; have_prev = 0; prev_tc0 = 32'd0;
      cyc = 0;
      while (edges0 < 1000 && cyc < 20000) begin
         @(negedge clk);
         if (cyc == 0) en_r = 2'b00;
         else begin
            en_r[0] = 1'b1;
            if ($urandom % 20 == 0) en_r[1] = ~en_r[1];
         end
         if ($urandom % 50 == 0) p1 = int'($urandom_range(20, 300));
         mn = model_min();
         if (mn == M) tn = cur + $urandom_range(0, 30);
         else if ($urandom % 4 != 0 || mn <= cur) tn = mn;
         else tn = cur + $urandom_range(0, mn - cur - 1);
         cur = tn;
         bus_a.en = en_r; bus_a.time_next = tn; bus_a.period = {16'(p1), 16'd100};
         #1;
         check_a("rand", m_tc[0], m_tc[1],
                 {model_eq(1, tn) != 0, model_eq(0, tn) != 0},
                 {m_cke[1] != 0, m_cke[0] != 0}, mn);
         if (have_prev != 0) begin
            delta = bus_a.time_clock[0] - prev_tc0;
            checks++;
            if (delta < 32'd1 || delta > 32'd227) begin
               errors++;
               $display("FAIL step0_range actual=%0d required=1..227", delta);
            end
            have_prev = 0;
         end
         if (model_eq(0, tn) != 0) begin
            prev_tc0 = bus_a.time_clock[0]; have_prev = 1; edges0++;
         end
         model_update(en_r, tn, 100, p1, 1'b1);
         cyc++;
      end
      checks++;
      if (edges0 < 1000) begin
         errors++;
         $display("FAIL rand_edges actual=%0d required=1000", edges0);
      end

      // Saturation: period 3 with first jitter -100 clamps the step to 1.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus_b.en = 1'b0; bus_b.time_next = 32'd0;
      @(negedge clk);
      bus_b.en = 1'b1; bus_b.time_next = 32'd10;
      @(negedge clk);
      bus_b.time_next = 32'd11;
      #1 chk("sat_sched", bus_b.time_clock[0], 32'd13);
      @(negedge clk);
      bus_b.time_next = 32'd13;
      #1 chk("sat_eq", {31'd0, bus_b.time_eq}, 32'd1);
      @(negedge clk);
      #1 chk("sat_step", bus_b.time_clock[0], 32'd14);
      chk("sat_cke", {31'd0, bus_b.cke_out}, 32'd1);
      @(negedge clk);
      bus_b.time_next = 32'd14;
      #1 chk("sat_eq2", {31'd0, bus_b.time_eq}, 32'd1);
      @(negedge clk);
      bus_b.time_next = 32'd20;
      #1 chk("sat_next", bus_b.time_clock[0], 32'd73);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
